// File: rtl/step_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : step_if_pkg
//  Purpose  : Shared types and constants for the stepper step interface
//             (decoder FSM encoding, direction polarity, period offset).
//  Revision : 1.0 - initial release
// ============================================================================
package step_if_pkg;

  // Decoder FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_MEAS  = 2'd2,
    ST_STALL = 2'd3
  } state_e;

  // Direction level meaning "count forward"
  localparam logic DIR_FWD = 1'b1;

  // A generator programmed with period N places rising edges N+3 clk apart
  localparam int GEN_PERIOD_OFFSET = 3;

endpackage : step_if_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Two-flop synchronizer for asynchronous level inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture of the asynchronous input into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/step_pulse_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : step_pulse_decoder
//  Purpose  : Recovers signed step position, step period (clk cycles) and
//             stall status from a driver-side step/dir pair.
//  Revision : 1.0 - initial release
// ============================================================================
module step_pulse_decoder #(
  parameter int SIZE    = 16,
  parameter int POS_W   = 32,
  parameter int TIMEOUT = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    step_in,
  input  logic                    dir_in,
  input  logic                    enable,
  input  logic                    clear_pos,
  output logic signed [POS_W-1:0] position,
  output logic        [SIZE-1:0]  period,
  output logic                    period_valid,
  output logic                    stall,
  output logic                    period_ovf
);

  import step_if_pkg::*;

  localparam logic [SIZE-1:0] CNT_MAX = '1;

  logic             step_s;
  logic             dir_s;
  logic             step_d3_q;
  logic             step_edge;
  logic             cnt_sat;
  logic             timeout_hit;

  state_e           state_q,   state_d;
  logic [SIZE-1:0]  cnt_q,     cnt_d;
  logic [SIZE-1:0]  period_q,  period_d;
  logic             pv_q,      pv_d;
  logic             stall_q,   stall_d;
  logic             ovf_q,     ovf_d;
  logic [POS_W-1:0] pos_q,     pos_d;

  sync_2ff #(.WIDTH(1)) u_sync_step (
    .clk   (clk),
    .rst_n (rst),
    .d_i   (step_in),
    .q_o   (step_s)
  );

  sync_2ff #(.WIDTH(1)) u_sync_dir (
    .clk   (clk),
    .rst_n (rst),
    .d_i   (dir_in),
    .q_o   (dir_s)
  );

  assign step_edge = step_s & ~step_d3_q;
  assign cnt_sat   = (cnt_q == CNT_MAX);
  // A TIMEOUT the counter can never reach simply disables stall detection
  assign timeout_hit = (32'(cnt_q) == 32'(TIMEOUT));

  // Third step flop feeding the rising-edge detector
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) step_d3_q <= 1'b0;
    else      step_d3_q <= step_s;
  end

  // Next-state logic: FSM, period counter, flags and position
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    pv_d     = 1'b0;
    stall_d  = stall_q;
    ovf_d    = ovf_q;
    pos_d    = pos_q;

    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      stall_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d   = '0;
          stall_d = 1'b0;
          state_d = ST_ARM;
        end
        ST_ARM: begin
          // First edge only marks the start point; nothing to measure yet
          if (step_edge) begin
            cnt_d   = SIZE'(1);
            state_d = ST_MEAS;
          end
        end
        ST_MEAS: begin
          // An edge wins over a coincident timeout
          if (step_edge) begin
            period_d = cnt_q;
            pv_d     = 1'b1;
            cnt_d    = SIZE'(1);
            if (cnt_sat) ovf_d = 1'b1;
          end else if (timeout_hit) begin
            state_d = ST_STALL;
            stall_d = 1'b1;
          end else if (!cnt_sat) begin
            cnt_d = cnt_q + SIZE'(1);
          end
        end
        ST_STALL: begin
          // Gap before this edge is not a valid period: restart measuring
          if (step_edge) begin
            stall_d = 1'b0;
            cnt_d   = SIZE'(1);
            state_d = ST_MEAS;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (clear_pos) begin
      pos_d = '0;
      ovf_d = 1'b0;
    end else if (enable && step_edge) begin
      pos_d = (dir_s == DIR_FWD) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
    end
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      stall_q  <= 1'b0;
      ovf_q    <= 1'b0;
      pos_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      stall_q  <= stall_d;
      ovf_q    <= ovf_d;
      pos_q    <= pos_d;
    end
  end

  assign position     = pos_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign stall        = stall_q;
  assign period_ovf   = ovf_q;

endmodule : step_pulse_decoder
`default_nettype wire
